// File: rtl/mosby_pkg.sv
// Shared definitions for the MOSby core: flag instruction encodings,
// processor status bit positions and the power-on status value.
package mosby_pkg;

   typedef enum logic [2:0] {
      FLAG_NOP = 3'd0,
      FLAG_CLC = 3'd1,
      FLAG_SEC = 3'd2,
      FLAG_CLI = 3'd3,
      FLAG_SEI = 3'd4,
      FLAG_CLV = 3'd5,
      FLAG_CLD = 3'd6,
      FLAG_SED = 3'd7
   } flag_op_e;

   // Bit positions inside the P byte
   localparam int P_N = 7;
   localparam int P_V = 6;
   localparam int P_U = 5;
   localparam int P_B = 4;
   localparam int P_D = 3;
   localparam int P_I = 2;
   localparam int P_Z = 1;
   localparam int P_C = 0;

   // I=1 and the unused bit 5 reads as 1
   localparam logic [7:0] RESET_P_DEFAULT = 8'h24;

endpackage

// File: rtl/status_reg_if.sv
// Bundle between the control unit/ALU (master) and the status register (slave).
interface status_reg_if;
   import mosby_pkg::*;

   logic       alu_n;
   logic       alu_v;
   logic       alu_z;
   logic       alu_c;
   logic       upd_nz;
   logic       upd_c;
   logic       upd_v;
   flag_op_e   flag_op;
   logic       bit_op;
   logic       plp_load;
   logic [7:0] data_in;
   logic       push_brk;
   logic [7:0] push_data;
   logic       instr_boundary;
   logic       irq;
   logic       nmi;
   logic       int_ack;
   logic [7:0] status;
   logic       int_pending;
   logic       int_is_nmi;

   modport master (
      output alu_n, alu_v, alu_z, alu_c, upd_nz, upd_c, upd_v, flag_op,
             bit_op, plp_load, data_in, push_brk, instr_boundary, irq, nmi, int_ack,
      input  push_data, status, int_pending, int_is_nmi
   );

   modport slave (
      input  alu_n, alu_v, alu_z, alu_c, upd_nz, upd_c, upd_v, flag_op,
             bit_op, plp_load, data_in, push_brk, instr_boundary, irq, nmi, int_ack,
      output push_data, status, int_pending, int_is_nmi
   );

endinterface

// File: rtl/nmi_edge_latch.sv
// NMI rising-edge detector with a pending flop. A fresh edge in the same
// cycle as the acknowledge keeps the request pending. After reset the input
// must be seen low once before a rising edge can be recognised, so an NMI
// line that is already high at reset release does not fire.
module nmi_edge_latch (
   input  logic clk,
   input  logic rst,
   input  logic nmi,
   input  logic ack,
   output logic nmi_pend
);

   logic nmi_q_reg;
   logic armed_reg;
   logic pend_reg;
   logic rise_seen;

   assign rise_seen = nmi & ~nmi_q_reg & armed_reg;
   assign nmi_pend  = pend_reg;

   // Sample the line, arm on the first low, set-wins pending flop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nmi_q_reg <= 1'b0;
         armed_reg <= 1'b0;
         pend_reg  <= 1'b0;
      end else begin
         nmi_q_reg <= nmi;
         if (!nmi) begin
            armed_reg <= 1'b1;
         end
         pend_reg <= rise_seen | (pend_reg & ~ack);
      end
   end

endmodule

// File: rtl/status_reg.sv
// Processor status register P: six flag flops with prioritised update
// sources, push-byte formatting and interrupt recognition (NMI edge latch,
// IRQ masked by the I value captured at the previous instruction boundary).
module status_reg
   import mosby_pkg::*;
#(
   parameter logic [7:0] RESET_P = RESET_P_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   status_reg_if.slave  bus
);

   logic n_reg, v_reg, d_reg, i_reg, z_reg, c_reg;
   logic n_next, v_next, d_next, i_next, z_next, c_next;
   logic i_mask_reg;
   logic nmi_pend;
   logic [7:0] p_word;
   logic [7:0] push_word;
   logic unused_data_bits;

   // Bits 5/4 of the data bus never reach a flag
   assign unused_data_bits = ^bus.data_in[P_U:P_B];

   // Next flag values; later assignments have higher precedence
   always_comb begin
      n_next = n_reg;
      v_next = v_reg;
      d_next = d_reg;
      i_next = i_reg;
      z_next = z_reg;
      c_next = c_reg;

      if (bus.upd_nz) begin
         n_next = bus.alu_n;
         z_next = bus.alu_z;
      end
      if (bus.upd_c) c_next = bus.alu_c;
      if (bus.upd_v) v_next = bus.alu_v;

      if (bus.bit_op) begin
         n_next = bus.data_in[P_N];
         v_next = bus.data_in[P_V];
         z_next = bus.alu_z;
      end

      case (bus.flag_op)
         FLAG_CLC: c_next = 1'b0;
         FLAG_SEC: c_next = 1'b1;
         FLAG_CLI: i_next = 1'b0;
         FLAG_SEI: i_next = 1'b1;
         FLAG_CLV: v_next = 1'b0;
         FLAG_CLD: d_next = 1'b0;
         FLAG_SED: d_next = 1'b1;
         default:  ;
      endcase

      if (bus.int_ack) i_next = 1'b1;

      if (bus.plp_load) begin
         n_next = bus.data_in[P_N];
         v_next = bus.data_in[P_V];
         d_next = bus.data_in[P_D];
         i_next = bus.data_in[P_I];
         z_next = bus.data_in[P_Z];
         c_next = bus.data_in[P_C];
      end
   end

   // Flag storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_reg <= RESET_P[P_N];
         v_reg <= RESET_P[P_V];
         d_reg <= RESET_P[P_D];
         i_reg <= RESET_P[P_I];
         z_reg <= RESET_P[P_Z];
         c_reg <= RESET_P[P_C];
      end else begin
         n_reg <= n_next;
         v_reg <= v_next;
         d_reg <= d_next;
         i_reg <= i_next;
         z_reg <= z_next;
         c_reg <= c_next;
      end
   end

   // IRQ mask follows I only at instruction boundaries (one-instruction latency)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_mask_reg <= 1'b1;
      end else if (bus.instr_boundary) begin
         i_mask_reg <= i_reg;
      end
   end

   nmi_edge_latch u_nmi (
      .clk      (clk),
      .rst      (rst),
      .nmi      (bus.nmi),
      .ack      (bus.int_ack & nmi_pend),
      .nmi_pend (nmi_pend)
   );

   // Assemble the status byte and the pushed byte
   always_comb begin
      p_word      = 8'h00;
      p_word[P_N] = n_reg;
      p_word[P_V] = v_reg;
      p_word[P_U] = 1'b1;
      p_word[P_B] = 1'b0;
      p_word[P_D] = d_reg;
      p_word[P_I] = i_reg;
      p_word[P_Z] = z_reg;
      p_word[P_C] = c_reg;
      push_word      = p_word;
      push_word[P_B] = bus.push_brk;
   end

   assign bus.status      = p_word;
   assign bus.push_data   = push_word;
   assign bus.int_is_nmi  = nmi_pend;
   assign bus.int_pending = nmi_pend | (bus.irq & ~i_mask_reg);

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the P register and interrupt rules.
module tb_status_reg;
   import mosby_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic chk_en = 1'b0;
   int   n_vec = 0;
   int   n_fail = 0;

   status_reg_if bus ();

   status_reg #(.RESET_P(8'h24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [7:0] m_p        = 8'h24;
   logic       m_imask    = 1'b1;
   logic       m_nmi_pend = 1'b0;
   logic       m_nmi_last = 1'b1;   // treated as high after reset: needs a low first

   // Apply sources lowest priority first so higher ones overwrite
   function automatic logic [7:0] next_p(input logic [7:0] p);
      logic [7:0] r;
      r = p;
      if (bus.upd_nz) begin r[7] = bus.alu_n; r[1] = bus.alu_z; end
      if (bus.upd_c) r[0] = bus.alu_c;
      if (bus.upd_v) r[6] = bus.alu_v;
      if (bus.bit_op) begin
         r[7] = bus.data_in[7]; r[6] = bus.data_in[6]; r[1] = bus.alu_z;
      end
      case (bus.flag_op)
         FLAG_CLC: r[0] = 1'b0;
         FLAG_SEC: r[0] = 1'b1;
         FLAG_CLI: r[2] = 1'b0;
         FLAG_SEI: r[2] = 1'b1;
         FLAG_CLV: r[6] = 1'b0;
         FLAG_CLD: r[3] = 1'b0;
         FLAG_SED: r[3] = 1'b1;
         default:  ;
      endcase
      if (bus.int_ack) r[2] = 1'b1;
      if (bus.plp_load) r = bus.data_in;
      r[5] = 1'b1;
      r[4] = 1'b0;
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_p        <= 8'h24;
         m_imask    <= 1'b1;
         m_nmi_pend <= 1'b0;
         m_nmi_last <= 1'b1;
      end else begin
         m_p <= next_p(m_p);
         if (bus.instr_boundary) m_imask <= m_p[2];
         if (bus.nmi && !m_nmi_last) m_nmi_pend <= 1'b1;
         else if (bus.int_ack && m_nmi_pend) m_nmi_pend <= 1'b0;
         m_nmi_last <= bus.nmi;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("status", bus.status, m_p);
            check("push_data", bus.push_data, m_p | {3'b000, bus.push_brk, 4'b0000});
            check("int_is_nmi", {7'd0, bus.int_is_nmi}, {7'd0, m_nmi_pend});
            check("int_pending", {7'd0, bus.int_pending},
                  {7'd0, m_nmi_pend | (bus.irq & ~m_imask)});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.alu_n = 0; bus.alu_v = 0; bus.alu_z = 0; bus.alu_c = 0;
      bus.upd_nz = 0; bus.upd_c = 0; bus.upd_v = 0;
      bus.flag_op = FLAG_NOP; bus.bit_op = 0; bus.plp_load = 0;
      bus.instr_boundary = 0; bus.int_ack = 0;
   endtask

   initial begin
      int rises;
      logic prev;
      idle();
      bus.data_in = 8'h00; bus.push_brk = 0; bus.irq = 0; bus.nmi = 0;
      #2 rst = 1;
      step();
      rst = 0;
      chk_en = 1;

      // Reset asserted mid-cycle after flags were disturbed
      bus.plp_load = 1; bus.data_in = 8'hFF; step(); idle();
      #2 rst = 1;
      #1;
      check("rst_status", bus.status, 8'h24);
      check("rst_pending", {7'd0, bus.int_pending}, 8'h00);
      bus.push_brk = 1; #1;
      check("rst_push_brk1", bus.push_data, 8'h34);
      bus.push_brk = 0; #1;
      check("rst_push_brk0", bus.push_data, 8'h24);
      step();
      rst = 0;

      // Precedence: PLP beats upd_c, then SEC with upd_nz
      bus.plp_load = 1; bus.data_in = 8'hFF; bus.upd_c = 1; bus.alu_c = 0;
      step(); idle();
      check("plp_over_updc", bus.status, 8'hEF);
      bus.flag_op = FLAG_SEC; bus.upd_nz = 1; bus.alu_n = 0; bus.alu_z = 1;
      step(); idle();
      check("sec_with_updnz", bus.status, 8'h6F);

      // BIT
      bus.plp_load = 1; bus.data_in = 8'h05; step(); idle();
      bus.bit_op = 1; bus.data_in = 8'hC0; bus.alu_z = 1; step(); idle();
      check("bit_op", bus.status, 8'hE7);

      // IRQ mask latency
      bus.instr_boundary = 1; step(); idle();
      bus.irq = 1; bus.flag_op = FLAG_CLI; bus.instr_boundary = 1; step(); idle();
      check("cli_clears_i", bus.status & 8'h04, 8'h00);
      check("irq_still_masked", {7'd0, bus.int_pending}, 8'h00);
      step();
      bus.instr_boundary = 1; step(); idle();
      check("irq_unmasked", {7'd0, bus.int_pending}, 8'h01);
      bus.int_ack = 1; step(); idle();
      check("ack_sets_i", bus.status & 8'h04, 8'h04);
      check("irq_not_nmi", {7'd0, bus.int_is_nmi}, 8'h00);
      bus.irq = 0; bus.instr_boundary = 1; step(); idle();
      bus.flag_op = FLAG_CLI; bus.int_ack = 1; step(); idle();
      check("cli_vs_ack", bus.status & 8'h04, 8'h04);

      // NMI held high: one latch only
      bus.nmi = 0; step();
      prev = bus.int_pending;
      rises = 0;
      bus.nmi = 1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (bus.int_pending && !prev) rises++;
         prev = bus.int_pending;
      end
      check("nmi_one_rise", 8'(rises), 8'd1);
      check("nmi_is_nmi", {7'd0, bus.int_is_nmi}, 8'h01);
      bus.int_ack = 1; step(); idle();
      check("nmi_ack_clears", {7'd0, bus.int_pending}, 8'h00);
      bus.nmi = 0; step();
      bus.nmi = 1; step();
      check("nmi_relatch", {7'd0, bus.int_is_nmi}, 8'h01);
      bus.nmi = 0; step();
      bus.nmi = 1; bus.int_ack = 1; step(); idle();
      check("nmi_set_wins", {7'd0, bus.int_is_nmi}, 8'h01);
      bus.int_ack = 1; step(); idle();
      check("nmi_cleared", {7'd0, bus.int_is_nmi}, 8'h00);

      // Reset while NMI pending, NMI still high after release
      bus.nmi = 0; step();
      bus.nmi = 1; step();
      check("nmi_pend_pre_rst", {7'd0, bus.int_is_nmi}, 8'h01);
      #2 rst = 1;
      #1;
      check("rst_drops_nmi", {7'd0, bus.int_is_nmi}, 8'h00);
      step();
      rst = 0;
      step(); step(); step();
      check("nmi_high_no_latch", {7'd0, bus.int_pending}, 8'h00);
      bus.nmi = 0; step();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 199) == 0);
         bus.alu_n = 1'($urandom); bus.alu_v = 1'($urandom);
         bus.alu_z = 1'($urandom); bus.alu_c = 1'($urandom);
         bus.upd_nz = 1'($urandom); bus.upd_c = 1'($urandom); bus.upd_v = 1'($urandom);
         bus.flag_op = ($urandom_range(0, 1) == 0) ? FLAG_NOP : flag_op_e'($urandom_range(0, 7));
         bus.bit_op = ($urandom_range(0, 5) == 0);
         bus.plp_load = ($urandom_range(0, 9) == 0);
         bus.data_in = 8'($urandom);
         bus.push_brk = 1'($urandom);
         bus.instr_boundary = ($urandom_range(0, 2) == 0);
         bus.int_ack = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 7) == 0) bus.irq = ~bus.irq;
         if ($urandom_range(0, 5) == 0) bus.nmi = ~bus.nmi;
         step();
      end
      rst = 0;
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/status_reg.md
# status_reg

Processor status register (P) for the MOSby core: holds N V D I Z C and updates them from ALU results, flag instructions, PLP/BIT data and the interrupt sequence. It is the writer of the 8-bit `status` bus read by the branch unit. It formats the byte pushed by PHP/BRK/IRQ/NMI. It also recognises interrupts: NMI edge latch, IRQ masked by I with the 6502 one-instruction mask latency.

## Interface
- `RESET_P`, default 8'h24, status value loaded on reset (I=1, bit5=1).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_n`, `alu_v`, `alu_z`, `alu_c` in 1 each: ALU result flags.
- `upd_nz` in 1: load N, Z from ALU.
- `upd_c` in 1: load C from ALU.
- `upd_v` in 1: load V from ALU.
- `flag_op` in 3: 0 NOP, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED.
- `bit_op` in 1: BIT; N<=data_in[7], V<=data_in[6], Z<=alu_z.
- `plp_load` in 1: load P from `data_in`.
- `data_in` in 8: data bus.
- `push_brk` in 1: selects B=1 in `push_data` (PHP/BRK), else B=0 (IRQ/NMI).
- `push_data` out 8: status with bit5=1 and bit4=push_brk.
- `instr_boundary` in 1: high for the last cycle of each instruction.
- `irq` in 1: level interrupt request, active-high.
- `nmi` in 1: non-maskable request, rising-edge sensitive.
- `int_ack` in 1: one-cycle pulse when the control unit enters the interrupt sequence.
- `status` out 8: {N,V,1,0,D,I,Z,C}.
- `int_pending` out 1: interrupt to be taken at the next boundary.
- `int_is_nmi` out 1: pending interrupt is NMI.

## Operation
- Storage: six flag flops. Bit5 reads 1 and bit4 reads 0 on `status`. B is never stored.
- Precedence within one cycle, highest first:
  1. `plp_load`: all six flags from `data_in`; bits 5 and 4 are ignored.
  2. `int_ack`: sets I.
  3. `flag_op`.
  4. `bit_op`.
  5. `upd_nz` / `upd_c` / `upd_v`.
- Lower-precedence sources only update flags that no higher source touches.
  - Example: SEC with `upd_nz` sets C and loads N, Z.
  - Example: `plp_load` with `upd_c` means PLP wins on C.
- NMI:
  - Register `nmi_q`; a rising edge (`nmi & ~nmi_q`) sets `nmi_pend`.
  - `int_ack` with `int_is_nmi` clears `nmi_pend`.
  - A new edge in the same cycle as the ack wins, and `nmi_pend` stays 1.
- IRQ mask latency:
  - `i_mask` is loaded with the pre-edge I on each clock where `instr_boundary`=1.
  - Therefore CLI/SEI/PLP change IRQ masking only after the following instruction completes.
- `int_pending` = `nmi_pend | (irq & ~i_mask)`, combinational.
- `int_is_nmi` = `nmi_pend`. NMI has priority over IRQ.
- IRQ is level-only. Dropping `irq` before `int_ack` withdraws it.

## Timing
- Reset (async, immediate):
  - `status`=`RESET_P`, `i_mask`=1, `nmi_pend`=0, `nmi_q`=0.
  - `int_pending`=0, `int_is_nmi`=0.
  - `push_data`=`RESET_P`|8'h20 with bit4=`push_brk`.
- All flag updates: one-cycle latency. The new value is visible on `status` after the capturing edge.
- `push_data`: combinational from current flags and `push_brk`, zero latency.
- NMI: edge sampled at clock N, so `int_pending` rises after edge N.
- `nmi` held high: one latch only. A second request needs a low then high.
- Reset mid-sequence: pending NMI is discarded. An `nmi` already high at reset release does not latch until it goes low then high.
- `flag_op` CLI with `int_ack` in the same cycle: I=1 (`int_ack` precedence).

## Structure
- Shared package `mosby_pkg`:
  - `flag_op` encodings.
  - Flag bit indices: N=7, V=6, U=5, B=4, D=3, I=2, Z=1, C=0.
  - Reset P constant 8'h24.
- Sub-module `nmi_edge_latch`: edge detector, pending flop, clear-on-ack with set-wins.
- Everything else stays flat in `status_reg`.

## Test plan
- Reset: assert `rst` mid-cycle; then all of:
  - `status`=8'h24.
  - `int_pending`=0.
  - `push_data`=8'h34 with `push_brk`=1, 8'h24 with `push_brk`=0.
- Precedence:
  - `plp_load` `data_in`=8'hFF with `upd_c`, `alu_c`=0 → `status`=8'hEF.
  - Then SEC + `upd_nz` with `alu_n`=0, `alu_z`=1 → C=1, N=0, Z=1.
- BIT: `data_in`=8'hC0, `alu_z`=1, `bit_op` → N=1, V=1, Z=1; C, D, I unchanged.
- IRQ latency:
  - With I=1, CLI, then `instr_boundary`: `irq`=1 gives `int_pending`=0.
  - After the next instruction's `instr_boundary`, `int_pending`=1.
  - `int_ack` → I=1.
- NMI:
  - `nmi` held high 10 cycles → exactly one `int_pending`, `int_is_nmi`=1.
  - `int_ack` clears it.
  - Low-high pulse in the ack cycle → `int_is_nmi` stays 1.
- Reset during pending NMI → `nmi_pend`=0. `nmi` still high after release → no pending.
